alu_op_sequencer: RTL and testbench

- Issue-side controller for the ALU datapath: accepts an opcode and two operands over a valid/ready handshake.
- Registers the operands and drives them to the function units.
- Generates the one-hot `sel` vector and `sub` flag consumed by the ALU output mux.
- Waits the required cycles, including a multi-cycle wait for multiply, captures the mux result, and presents it downstream over a second valid/ready handshake.

---
 rtl/alu_op_sequencer.sv | 124 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issue-side sequencer for the ALU datapath (optional ALU_SEQ_BACK2BACK_EN)
module alu_op_sequencer #(
  parameter int K        = 7,
  parameter int MULT_LAT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [K-1:0] in_a,
  input  logic [K-1:0] in_b,
  output logic [K-1:0] opa,
  output logic [K-1:0] opb,
  output logic         sub,
  output logic [5:0]   sel,
  input  logic [K-1:0] mux_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_result,
  output logic         out_err
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT - 1);

  state_t       state_q;
  logic [3:0]   cnt_q;
  logic [K-1:0] opa_q, opb_q, out_result_q;
  logic [5:0]   sel_q;
  logic         sub_q, out_err_q;

  logic [5:0]   sel_d;
  logic         sub_d;
  logic         accept;

  always_comb begin
    sel_d = 6'b000000;
    sub_d = 1'b0;
    case (in_op)
      3'd0:    sel_d = 6'b000001;
      3'd1:    sel_d = 6'b000010;
      3'd2:    sel_d = 6'b000100;
      3'd3:    sel_d = 6'b001000;
      3'd4:    sel_d = 6'b010000;
      3'd5:    begin sel_d = 6'b010000; sub_d = 1'b1; end
      3'd6:    sel_d = 6'b100000;
      default: sel_d = 6'b000000;
    endcase
  end

  // With back-to-back enabled, DONE can hand over to the next op on the output handshake edge.
  always_comb begin
`ifdef ALU_SEQ_BACK2BACK_EN
    in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
`else
    in_ready = (state_q == S_IDLE);
`endif
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      opa_q        <= '0;
      opb_q        <= '0;
      sel_q        <= 6'b000000;
      sub_q        <= 1'b0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
    end else if (accept) begin
      opa_q <= in_a;
      opb_q <= in_b;
      sel_q <= sel_d;
      sub_q <= sub_d;
      if (in_op == 3'd7) begin
        state_q      <= S_DONE;
        out_err_q    <= 1'b1;
        out_result_q <= '0;
      end else if (in_op == 3'd6) begin
        state_q <= S_WAIT;
        cnt_q   <= MULT_LOAD;
      end else begin
        state_q <= S_EXEC;
      end
    end else begin
      case (state_q)
        S_EXEC: begin
          out_result_q <= mux_in;
          out_err_q    <= 1'b0;
          sel_q        <= 6'b000000;
          sub_q        <= 1'b0;
          state_q      <= S_DONE;
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            out_result_q <= mux_in;
            out_err_q    <= 1'b0;
            sel_q        <= 6'b000000;
            state_q      <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign opa        = opa_q;
  assign opb        = opb_q;
  assign sel        = sel_q;
  assign sub        = sub_q;
  assign out_valid  = (state_q == S_DONE);
  assign out_result = out_result_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed and randomized checks of alu_op_sequencer against an opcode-level model
module tb_alu_op_sequencer;
  localparam int K        = 7;
  localparam int MULT_LAT = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = 3'd0;
  logic [K-1:0] in_a = '0;
  logic [K-1:0] in_b = '0;
  logic [K-1:0] opa, opb;
  logic         sub;
  logic [5:0]   sel;
  logic [K-1:0] mux_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [K-1:0] out_result;
  logic         out_err;

  int tests  = 0;
  int failed = 0;

  alu_op_sequencer #(.K(K), .MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .opa(opa), .opb(opb),
    .sub(sub), .sel(sel), .mux_in(mux_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [K-1:0] ref_result(input int op, input logic [K-1:0] a, input logic [K-1:0] b);
    logic [31:0] r;
    case (op)
      0: r = {25'd0, a & b};
      1: r = {25'd0, a | b};
      2: r = {25'd0, a ^ b};
      3: r = {25'd0, ~a};
      4: r = 32'(a) + 32'(b);
      5: r = 32'(a) - 32'(b);
      6: r = 32'(a) * 32'(b);
      default: r = 32'd0;
    endcase
    return r[K-1:0];
  endfunction

  function automatic logic [5:0] ref_sel(input int op);
    if (op <= 3) return 6'(1 << op);
    if (op == 4 || op == 5) return 6'b010000;
    if (op == 6) return 6'b100000;
    return 6'b000000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input int op, input logic [K-1:0] a, input logic [K-1:0] b, input int stall);
    int lat;
    logic [K-1:0] exp_r;
    exp_r = ref_result(op, a, b);
    lat = (op == 7) ? 1 : (op == 6) ? 1 + MULT_LAT : 2;
    @(negedge clk);
    in_valid = 1'b1; in_op = op[2:0]; in_a = a; in_b = b;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("out_valid_timing", 32'(out_valid), 32'(c == lat));
      check("opa", 32'(opa), 32'(a));
      check("opb", 32'(opb), 32'(b));
      if (c < lat) begin
        check("sel_exec", 32'(sel), 32'(ref_sel(op)));
        check("sub_exec", 32'(sub), 32'(op == 5));
        check("in_ready_busy", 32'(in_ready), 32'd0);
        mux_in = (c == lat - 1) ? exp_r : (exp_r ^ K'($urandom_range(1, 127)));
      end
    end
    check("out_result", 32'(out_result), 32'(exp_r));
    check("out_err", 32'(out_err), 32'(op == 7));
    check("sel_done", 32'(sel), 32'd0);
    check("sub_done", 32'(sub), 32'd0);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1; in_op = 3'($urandom); in_a = K'($urandom); mux_in = K'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_result", 32'(out_result), 32'(exp_r));
      check("stall_err", 32'(out_err), 32'(op == 7));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_opa", 32'(opa), 32'(a));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", 32'(out_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_sub", 32'(sub), 32'd0);
    check("rst_opa", 32'(opa), 32'd0);
    check("rst_opb", 32'(opb), 32'd0);
    check("rst_result", 32'(out_result), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rel_idle_ready", 32'(in_ready), 32'd1);
      check("rel_idle_valid", 32'(out_valid), 32'd0);
      check("rel_idle_sel", 32'(sel), 32'd0);
    end

    run_op(0, 7'h55, 7'h0F, 0);
    check("and_value", 32'(out_result), 32'h05);
    run_op(5, 7'h10, 7'h03, 5);
    run_op(6, 7'h05, 7'h06, 1);
    run_op(7, 7'h12, 7'h34, 2);

    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(0, 7)), K'($urandom), K'($urandom), int'($urandom_range(0, 2)));

    // Reset asserted in the second cycle of a multiply.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd6; in_a = 7'h05; in_b = 7'h06;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; mux_in = 7'h1E;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_sel", 32'(sel), 32'd0);
    check("midrst_opa", 32'(opa), 32'd0);
    check("midrst_result", 32'(out_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_valid", 32'(out_valid), 32'd0);
      check("midrst_idle", 32'(in_ready), 32'd1);
    end

`ifdef ALU_SEQ_BACK2BACK_EN
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd1; in_a = 7'h21; in_b = 7'h44;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; mux_in = ref_result(1, 7'h21, 7'h44);
    @(negedge clk);
    check("b2b_first_valid", 32'(out_valid), 32'd1);
    check("b2b_first_result", 32'(out_result), 32'(ref_result(1, 7'h21, 7'h44)));
    check("b2b_ready_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1; in_valid = 1'b1; in_op = 3'd4; in_a = 7'h3A; in_b = 7'h51;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0; mux_in = ref_result(4, 7'h3A, 7'h51);
    check("b2b_c1_valid", 32'(out_valid), 32'd0);
    check("b2b_c1_sel", 32'(sel), 32'b010000);
    check("b2b_c1_opa", 32'(opa), 32'h3A);
    @(negedge clk);
    check("b2b_c2_valid", 32'(out_valid), 32'd1);
    check("b2b_c2_result", 32'(out_result), 32'(ref_result(4, 7'h3A, 7'h51)));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_back_idle", 32'(out_valid), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
